// File: rtl/fabric_cfg_loader.sv
// fabric_cfg_loader: byte-serial configuration frame loader for the routing/IO fabric.
// A frame is SYNC followed by NBYTES payload bytes, little-endian by byte. The payload is
// assembled in a shadow register. It is copied onto cfg in a single commit cycle, so the
// fabric never sees a partially loaded configuration.
// Build option: define CFG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
// A frame whose checksum does not match is rejected with an err pulse.
module fabric_cfg_loader #(
  parameter int          CFG_W = 84,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic [CFG_W-1:0] cfg,
  output logic             cfg_loaded,
  output logic             done,
  output logic             err
);

  localparam int NBYTES = (CFG_W + 7) / 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
`ifdef CFG_LOADER_CHECKSUM_EN
    S_CHECK  = 2'd2,
`endif
    S_COMMIT = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [CFG_W-1:0]   shadow;
  logic               accept;
  logic               last_byte;
  logic               abort_ok;
  logic               start;
  logic               load_wr;
  logic               commit;
  logic               reject;
`ifdef CFG_LOADER_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  assign accept    = in_valid & in_ready;
  assign last_byte = (count == CNT_W'(NBYTES - 1));
  // abort is honoured everywhere except the commit cycle, which always completes
  assign abort_ok  = abort && (state != S_COMMIT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort overrides any transition, including the last-byte one
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (accept && in_data == SYNC) state_nxt = S_LOAD;
`ifdef CFG_LOADER_CHECKSUM_EN
      S_LOAD:   if (accept && last_byte) state_nxt = S_CHECK;
      S_CHECK:  if (accept) state_nxt = (in_data == csum) ? S_COMMIT : S_IDLE;
`else
      S_LOAD:   if (accept && last_byte) state_nxt = S_COMMIT;
`endif
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort_ok) state_nxt = S_IDLE;
  end

  // Output / strobe decode from the current state
  always_comb begin
    in_ready = (state != S_COMMIT);
    start    = (state == S_IDLE) && accept && (in_data == SYNC) && !abort_ok;
    load_wr  = (state == S_LOAD) && accept && !abort_ok;
    commit   = (state == S_COMMIT);
    reject   = 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
    reject   = (state == S_CHECK) && accept && (in_data != csum) && !abort_ok;
`endif
  end

  // Shadow assembly, byte counter and commit of the shadow onto the fabric bus
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      shadow     <= '0;
      cfg        <= '0;
      cfg_loaded <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= commit;
      if (commit) begin
        cfg        <= shadow;
        cfg_loaded <= 1'b1;
      end
      if (abort_ok || start) begin
        count  <= '0;
        shadow <= '0;
      end else if (load_wr) begin
        // bits of the last byte beyond CFG_W have no destination and are dropped
        for (int i = 0; i < CFG_W; i++) begin
          if (count == CNT_W'(i / 8)) shadow[i] <= in_data[3'(i % 8)];
        end
        count <= count + CNT_W'(1);
      end
    end
  end

`ifdef CFG_LOADER_CHECKSUM_EN
  // Running XOR of the payload and the rejection pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
      err  <= 1'b0;
    end else begin
      err <= reject;
      if (abort_ok || start) csum <= '0;
      else if (load_wr)      csum <= csum ^ in_data;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// tb_fabric_cfg_loader: directed bench for fabric_cfg_loader.
// Define CFG_LOADER_CHECKSUM_EN for both files to exercise the checksum build.
module tb_fabric_cfg_loader;

  localparam int CFG_W = 84;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             abort;
  logic [CFG_W-1:0] cfg;
  logic             cfg_loaded;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;

  localparam logic [87:0]      FRAME_A = 88'hBB_AA_99_88_77_66_55_A5_33_22_11;
  localparam logic [CFG_W-1:0] CFG_A   = 84'hB_AA_99_88_77_66_55_A5_33_22_11;
  localparam logic [87:0]      FRAME_B = 88'h01_02_03_04_05_06_07_08_09_0A_0B;
  localparam logic [CFG_W-1:0] CFG_B   = 84'h1_02_03_04_05_06_07_08_09_0A_0B;
  localparam logic [87:0]      FRAME_C = 88'hFF_5A_5A_5A_5A_5A_5A_5A_5A_5A_C3;
  localparam logic [CFG_W-1:0] CFG_C   = 84'hF_5A_5A_5A_5A_5A_5A_5A_5A_5A_C3;

  fabric_cfg_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .abort      (abort),
    .cfg        (cfg),
    .cfg_loaded (cfg_loaded),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b, input logic ab);
    in_valid = 1'b1;
    in_data  = b;
    abort    = ab;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
  endtask

  // Sends SYNC + payload (+ checksum in the checksum build). Returns just after the
  // final accepting edge, i.e. during the commit (or reject) cycle.
  task automatic send_frame(input logic [87:0] p, input bit gaps, input logic [7:0] cs_delta);
    logic [7:0] cs;
    cs = 8'h00;
    put(8'hA5, 1'b0);
    for (int k = 0; k < 11; k++) begin
      if (gaps) begin
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL gap_ready byte %0d: got %b, required 1", k, in_ready);
        end
      end
      cs = cs ^ p[8*k +: 8];
      put(p[8*k +: 8], 1'b0);
    end
`ifdef CFG_LOADER_CHECKSUM_EN
    if (gaps) tick();
    put(cs ^ cs_delta, 1'b0);
`else
    if (cs_delta != cs_delta) tick();
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; abort = 1'b0;
    tick(); tick();
    checks++; if (cfg !== '0) begin errors++; $display("FAIL reset_cfg: got %h, required 0", cfg); end
    checks++; if (cfg_loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded: got %b, required 0", cfg_loaded); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", in_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_bit();
    send_frame(88'h80, 1'b0, 8'h00);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_commit_ready: got %b, required 0", in_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_early: got %b, required 0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b, required 1", done); end
    checks++; if (cfg !== 84'h80) begin errors++; $display("FAIL single_cfg: got %h, required %h", cfg, 84'h80); end
    checks++; if (cfg_loaded !== 1'b1) begin errors++; $display("FAIL single_loaded: got %b, required 1", cfg_loaded); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b, required 0", err); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b, required 0", done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready_after: got %b, required 1", in_ready); end
  endtask

  task automatic test_drop_leading();
    put(8'h3C, 1'b0);
    put(8'h11, 1'b0);
    tick();
    checks++; if (cfg !== 84'h80) begin errors++; $display("FAIL drop_cfg_held: got %h, required %h", cfg, 84'h80); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL drop_done: got %b, required 0", done); end
    send_frame({11{8'hFF}}, 1'b0, 8'h00);
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL drop_done_commit: got %b, required 1", done); end
    checks++; if (cfg !== {CFG_W{1'b1}}) begin errors++; $display("FAIL drop_cfg_ones: got %h, required all ones", cfg); end
    tick();
  endtask

  task automatic test_gaps();
    send_frame(FRAME_A, 1'b1, 8'h00);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL gaps_commit_ready: got %b, required 0", in_ready); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL gaps_done: got %b, required 1", done); end
    checks++; if (cfg !== CFG_A) begin errors++; $display("FAIL gaps_cfg: got %h, required %h", cfg, CFG_A); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL gaps_done_pulse: got %b, required 0", done); end
  endtask

  task automatic test_abort();
    put(8'hA5, 1'b0);
    for (int k = 0; k < 5; k++) put(8'hE0 + 8'(k), 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b, required 0", done); end
    tick();
    checks++; if (cfg !== CFG_A) begin errors++; $display("FAIL abort_cfg_held: got %h, required %h", cfg, CFG_A); end
    send_frame(FRAME_B, 1'b0, 8'h00);
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_b_done: got %b, required 1", done); end
    checks++; if (cfg !== CFG_B) begin errors++; $display("FAIL abort_b_cfg: got %h, required %h", cfg, CFG_B); end
    tick();
    // abort on the same edge as the last payload byte
    put(8'hA5, 1'b0);
    for (int k = 0; k < 10; k++) put(FRAME_C[8*k +: 8], 1'b0);
    put(FRAME_C[87:80], 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_last_ready: got %b, required 1", in_ready); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_last_done: got %b, required 0", done); end
    checks++; if (cfg !== CFG_B) begin errors++; $display("FAIL abort_last_cfg: got %h, required %h", cfg, CFG_B); end
    // abort raised during the commit cycle does not stop the commit
    send_frame(FRAME_C, 1'b0, 8'h00);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_commit_done: got %b, required 1", done); end
    checks++; if (cfg !== CFG_C) begin errors++; $display("FAIL abort_commit_cfg: got %h, required %h", cfg, CFG_C); end
    tick();
  endtask

  task automatic test_rst_mid();
    put(8'hA5, 1'b0);
    for (int k = 0; k < 4; k++) put(8'h77, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (cfg !== '0) begin errors++; $display("FAIL rst_mid_cfg: got %h, required 0", cfg); end
    checks++; if (cfg_loaded !== 1'b0) begin errors++; $display("FAIL rst_mid_loaded: got %b, required 0", cfg_loaded); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b, required 1", in_ready); end
    send_frame(FRAME_B, 1'b0, 8'h00);
    tick();
    checks++; if (cfg !== CFG_B) begin errors++; $display("FAIL rst_mid_reload: got %h, required %h", cfg, CFG_B); end
    checks++; if (cfg_loaded !== 1'b1) begin errors++; $display("FAIL rst_mid_loaded_again: got %b, required 1", cfg_loaded); end
    tick();
  endtask

`ifdef CFG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    send_frame(FRAME_A, 1'b0, 8'h01);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL csum_err: got %b, required 1", err); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL csum_done: got %b, required 0", done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL csum_ready: got %b, required 1", in_ready); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL csum_err_pulse: got %b, required 0", err); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL csum_no_done: got %b, required 0", done); end
    checks++; if (cfg !== CFG_B) begin errors++; $display("FAIL csum_cfg_held: got %h, required %h", cfg, CFG_B); end
    send_frame(FRAME_A, 1'b0, 8'h00);
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL csum_ok_done: got %b, required 1", done); end
    checks++; if (cfg !== CFG_A) begin errors++; $display("FAIL csum_ok_cfg: got %h, required %h", cfg, CFG_A); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_bit();
    test_drop_leading();
    test_gaps();
    test_abort();
    test_rst_mid();
`ifdef CFG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
